// File: rtl/complementador_serial.sv
// -----------------------------------------------------------------------------
// complementador_serial
//
// Purpose:
//   Digit-serial complement unit for the DS-ALU datapath. One operand is
//   processed DIGIT bits per cycle, least significant digit first. Each
//   operand is handled in one of four modes:
//     00 pass, 01 ones' complement, 10 two's complement, 11 absolute value.
//   Valid/ready handshakes sit on both the input side and the output side.
//
// Parameters:
//   WIDTH  operand width in bits (>= 2)
//   DIGIT  bits processed per cycle; it must divide WIDTH exactly
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operand offered
//   in_ready   unit can accept an operand (IDLE only)
//   x          operand, two's-complement interpretation
//   mode       operation select
//   out_valid  result available (DONE)
//   out_ready  consumer takes the result
//   z          result
//   overflow   result not representable (negating the most-negative value)
//
// Configuration macro:
//   COMPL_SATURATE_EN  when defined, an overflowing result is replaced by
//                      the most-positive value 0111..1. When it is not
//                      defined, the result wraps modulo 2^WIDTH.
// -----------------------------------------------------------------------------
module complementador_serial #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] z,
  output logic             overflow
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};

  generate
    if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : gParamCheck
      $error("complementador_serial: WIDTH must be >= 2 and divisible by DIGIT");
    end
  endgenerate

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] z_q, z_d;
  logic             inv_q, inv_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ovfPend_q, ovfPend_d;
  logic             ovf_q, ovf_d;

  logic [DIGIT:0]   sum;
  logic [WIDTH-1:0] accNext;
  logic             xNeg;

  assign xNeg = x[WIDTH-1];

  // One digit of (operand ^ inv) + carry. The bit above the digit is the
  // carry into the next digit. The carry out of the final digit is dropped.
  assign sum = {1'b0, shreg_q[DIGIT-1:0] ^ {DIGIT{inv_q}}} + {{DIGIT{1'b0}}, carry_q};

  // New result digits enter at the MSB end. After NDIG shifts, the first
  // digit has reached bit 0.
  generate
    if (DIGIT == WIDTH) begin : gAccWhole
      assign accNext = sum[DIGIT-1:0];
    end else begin : gAccShift
      assign accNext = {sum[DIGIT-1:0], acc_q[WIDTH-1:DIGIT]};
    end
  endgenerate

  // The result is built in acc_q. It is copied to z_q only when the last
  // digit is done, so z never shows a partial result.
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    acc_d     = acc_q;
    z_d       = z_q;
    inv_d     = inv_q;
    carry_d   = carry_q;
    cnt_d     = cnt_q;
    ovfPend_d = ovfPend_q;
    ovf_d     = ovf_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          shreg_d   = x;
          acc_d     = '0;
          cnt_d     = '0;
          inv_d     = (mode == 2'b01) | (mode == 2'b10) | ((mode == 2'b11) & xNeg);
          carry_d   = (mode == 2'b10) | ((mode == 2'b11) & xNeg);
          ovfPend_d = mode[1] & (x == MIN_NEG);
          state_d   = RUN;
        end
      end
      RUN: begin
        shreg_d = shreg_q >> DIGIT;
        acc_d   = accNext;
        carry_d = sum[DIGIT];
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(NDIG - 1)) begin
          state_d = DONE;
          ovf_d   = ovfPend_q;
`ifdef COMPL_SATURATE_EN
          z_d     = ovfPend_q ? MAX_POS : accNext;
`else
          z_d     = accNext;
`endif
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // All state is cleared asynchronously. An operand that is in flight when
  // reset arrives is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      acc_q     <= '0;
      z_q       <= '0;
      inv_q     <= 1'b0;
      carry_q   <= 1'b0;
      cnt_q     <= '0;
      ovfPend_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      acc_q     <= acc_d;
      z_q       <= z_d;
      inv_q     <= inv_d;
      carry_q   <= carry_d;
      cnt_q     <= cnt_d;
      ovfPend_q <= ovfPend_d;
      ovf_q     <= ovf_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign z         = z_q;
  assign overflow  = ovf_q;

  // MAX_POS is referenced only in the saturating build.
  logic unusedMaxPos;
  assign unusedMaxPos = ^MAX_POS;

endmodule
